// File: rtl/cv_pkg.sv
// cv_pkg: shared widths and serializer FSM state encoding
package cv_pkg;
  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_t;
endpackage

// File: rtl/cv_word_fifo.sv
// cv_word_fifo: word FIFO feeding the output serializer
// Ports: clk, rst (async, active-low), push/wr_data write side,
//        pop/rd_data read side (rd_data shows the head word), count = words held.
// The caller must never push when full or pop when empty.
module cv_word_fifo import cv_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W = WORD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/cv_out_serializer.sv
// cv_out_serializer: buffers 16-bit cipher words and emits them as two bytes
// Ports: clk, rst (async, active-low); in_data/in_valid/in_ready word input;
//        out_byte/out_valid/out_ready/out_last byte output; fifo_count = queued
//        words (excluding the word being serialized); overflow sticky drop flag,
//        cleared by clr_ovf; out_parity (even parity of out_byte) only when
//        CV_OUT_PARITY_EN is defined.
module cv_out_serializer import cv_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [BYTE_W-1:0]      out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
`ifdef CV_OUT_PARITY_EN
  output logic                   out_parity,
`endif
  input  logic                   clr_ovf
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, nxt;
  logic [WORD_W-1:0] sr, head;
  logic empty, load, pop, bypass, push;
  assign in_ready = fifo_count != CW'(DEPTH);
  assign empty = fifo_count == '0;
  // The shift register can take a new word when idle or when its last byte leaves.
  assign load = state == IDLE || (state == BYTE1 && out_ready);
  assign pop = load && !empty;
  // With nothing queued, an arriving word goes straight to the shift register,
  // giving one-cycle latency and bubble-free streaming.
  assign bypass = load && empty && in_valid;
  assign push = in_valid && in_ready && !bypass;
  cv_word_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wr_data(in_data),
    .rd_data(head),
    .count(fifo_count)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = (pop || bypass) ? BYTE0 :
          (state == BYTE0 && out_ready) ? BYTE1 :
          (state == BYTE1 && out_ready) ? IDLE : state;
  end
  always_comb begin
    out_valid = state != IDLE;
    out_last = state == BYTE1;
    out_byte = state == IDLE ? '0 : (MSB_FIRST != 0) ? sr[WORD_W-1:BYTE_W] : sr[BYTE_W-1:0];
  end
  // The second byte is shifted into the output position once the first is taken.
  always_ff @(posedge clk or negedge rst)
    if (!rst) sr <= '0;
    else if (pop) sr <= head;
    else if (bypass) sr <= in_data;
    else if (state == BYTE0 && out_ready)
      sr <= (MSB_FIRST != 0) ? {sr[BYTE_W-1:0], {BYTE_W{1'b0}}} : {{BYTE_W{1'b0}}, sr[WORD_W-1:BYTE_W]};
  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rst)
    if (!rst) overflow <= 1'b0;
    else if (in_valid && !in_ready) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
`ifdef CV_OUT_PARITY_EN
  assign out_parity = ^out_byte;
`endif
endmodule

// File: tb/tb_cv_out_serializer.sv
// tb_cv_out_serializer: directed self-checking bench for cv_out_serializer
module tb_cv_out_serializer;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] a_in_data, b_in_data;
  logic a_in_valid, b_in_valid, a_out_ready, b_out_ready, a_clr, b_clr;
  logic a_in_ready, b_in_ready, a_out_valid, b_out_valid, a_out_last, b_out_last;
  logic a_ovf, b_ovf;
  logic [7:0] a_out_byte, b_out_byte;
  logic [2:0] a_cnt, b_cnt;
`ifdef CV_OUT_PARITY_EN
  logic a_par, b_par;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cv_out_serializer #(.DEPTH(4), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_byte(a_out_byte), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last),
    .fifo_count(a_cnt), .overflow(a_ovf),
`ifdef CV_OUT_PARITY_EN
    .out_parity(a_par),
`endif
    .clr_ovf(a_clr)
  );
  cv_out_serializer #(.DEPTH(4), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_byte(b_out_byte), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last),
    .fifo_count(b_cnt), .overflow(b_ovf),
`ifdef CV_OUT_PARITY_EN
    .out_parity(b_par),
`endif
    .clr_ovf(b_clr)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input logic v, input logic [7:0] b, input logic l);
    chk({tag, "_valid"}, 16'(a_out_valid), 16'(v));
    chk({tag, "_byte"}, 16'(a_out_byte), 16'(b));
    chk({tag, "_last"}, 16'(a_out_last), 16'(l));
  endtask
  initial begin
    {a_in_data, b_in_data} = '0;
    {a_in_valid, b_in_valid, a_out_ready, b_out_ready, a_clr, b_clr} = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk_a("rst0", 1'b0, 8'h00, 1'b0);
    chk("rst0_cnt", 16'(a_cnt), 16'd0);
    chk("rst0_rdy", 16'(a_in_ready), 16'd1);
    chk("rst0_ovf", 16'(a_ovf), 16'd0);
    @(negedge clk) rst = 1'b1;
    tick;
    // two words streamed back to back, high byte first
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    a_in_data = 16'hE1E1;
    tick;
    chk_a("s1", 1'b1, 8'hE1, 1'b0);
    a_in_data = 16'h1234;
    tick;
    chk_a("s2", 1'b1, 8'hE1, 1'b1);
    a_in_valid = 1'b0;
    tick;
    chk_a("s3", 1'b1, 8'h12, 1'b0);
    tick;
    chk_a("s4", 1'b1, 8'h34, 1'b1);
    tick;
    chk("s5_valid", 16'(a_out_valid), 16'd0);
    chk("s5_cnt", 16'(a_cnt), 16'd0);
    // low byte first instance
    b_out_ready = 1'b1;
    b_in_valid = 1'b1;
    b_in_data = 16'hABCD;
    tick;
    b_in_valid = 1'b0;
    chk("lsb0_byte", 16'(b_out_byte), 16'h00CD);
    chk("lsb0_last", 16'(b_out_last), 16'd0);
    tick;
    chk("lsb1_byte", 16'(b_out_byte), 16'h00AB);
    chk("lsb1_last", 16'(b_out_last), 16'd1);
    // fill: one word in the shift register, four queued, then a dropped word
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 16'h1111;
    tick;
    a_in_data = 16'h2222;
    tick;
    a_in_data = 16'h3333;
    tick;
    chk("fill_cnt2", 16'(a_cnt), 16'd2);
    a_in_data = 16'h4444;
    tick;
    a_in_data = 16'h5555;
    tick;
    chk("full_cnt", 16'(a_cnt), 16'd4);
    chk("full_rdy", 16'(a_in_ready), 16'd0);
    chk("full_ovf", 16'(a_ovf), 16'd0);
    chk_a("full", 1'b1, 8'h11, 1'b0);
    a_in_data = 16'h6666;
    tick;
    chk("drop_ovf", 16'(a_ovf), 16'd1);
    chk("drop_cnt", 16'(a_cnt), 16'd4);
    a_in_valid = 1'b0;
    a_clr = 1'b1;
    tick;
    a_clr = 1'b0;
    chk("clr_ovf", 16'(a_ovf), 16'd0);
    // stall in BYTE0, then release
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_a("stall", 1'b1, 8'h11, 1'b0);
    end
    a_out_ready = 1'b1;
    tick;
    chk_a("rel1", 1'b1, 8'h11, 1'b1);
    tick;
    chk_a("rel2", 1'b1, 8'h22, 1'b0);
    chk("rel2_cnt", 16'(a_cnt), 16'd3);
    tick;
    chk_a("rel3", 1'b1, 8'h22, 1'b1);
    // push and pop on the same edge at count DEPTH-1
    a_in_valid = 1'b1;
    a_in_data = 16'h7777;
    tick;
    a_in_valid = 1'b0;
    chk_a("pp", 1'b1, 8'h33, 1'b0);
    chk("pp_cnt", 16'(a_cnt), 16'd3);
    tick;
    tick;
    chk_a("q44", 1'b1, 8'h44, 1'b0);
    tick;
    chk_a("q44b", 1'b1, 8'h44, 1'b1);
    chk("q44b_cnt", 16'(a_cnt), 16'd2);
    // reset mid-word with two words queued
    rst = 1'b0;
    #1;
    chk_a("mrst", 1'b0, 8'h00, 1'b0);
    chk("mrst_cnt", 16'(a_cnt), 16'd0);
    chk("mrst_rdy", 16'(a_in_ready), 16'd1);
    chk("mrst_ovf", 16'(a_ovf), 16'd0);
    tick;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post_rst_valid", 16'(a_out_valid), 16'd0);
    end
    a_in_valid = 1'b1;
    a_in_data = 16'hAA55;
    tick;
    a_in_valid = 1'b0;
    chk_a("new0", 1'b1, 8'hAA, 1'b0);
    tick;
    chk_a("new1", 1'b1, 8'h55, 1'b1);
    tick;
`ifdef CV_OUT_PARITY_EN
    a_in_valid = 1'b1;
    a_in_data = 16'h0703;
    tick;
    a_in_valid = 1'b0;
    chk("par07", 16'(a_par), 16'd1);
    tick;
    chk("par03", 16'(a_par), 16'd0);
    tick;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
